// File: rtl/cpu_pkg.sv
// Constants shared by the front end and the control unit: instruction field positions,
// the HALT encoding and the fetch FSM state type.
package cpu_pkg;

  localparam logic [15:0] INSTR_NOP  = 16'h0000;
  localparam logic [3:0]  OP_HALT    = 4'h0;
  localparam logic [3:0]  FUNCT_HALT = 4'h0;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 8;
  localparam int RT_MSB    = 7;
  localparam int RT_LSB    = 4;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;
  localparam int IMM8_MSB  = 7;
  localparam int IMM8_LSB  = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fe_state_t;

  // HALT is the all-zero word; the caller still has to qualify it with a valid slot.
  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[OP_MSB:OP_LSB] == OP_HALT) &&
           (instr[FUNCT_MSB:FUNCT_LSB] == FUNCT_HALT) &&
           (instr == INSTR_NOP);
  endfunction

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter: redirect load has priority over hold, otherwise advance by one word
// with natural modulo-2^PC_W wrap.
module fetch_pc_counter #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-1){1'b0}}, 1'b1};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (!hold) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Pipeline front end: PC, IF/ID register, HALT detection FSM, field split for the control
// unit and register file, and a saturating count of delivered instructions.
module fetch_decode_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [3:0]         id_op,
  output logic [3:0]         id_funct,
  output logic [3:0]         id_rs,
  output logic [3:0]         id_rt,
  output logic [7:0]         id_imm8,
  output logic [PC_W-1:0]    id_pc,
  output logic               id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt
);

  localparam logic [CNT_W-1:0] CNT_STEP = {{(CNT_W-1){1'b0}}, 1'b1};

  fe_state_t          state;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    pc;
  logic               halt_in_id;
  logic               pc_hold;
  logic               pc_load;

  // A squashing redirect or a stall in the same cycle keeps the HALT from retiring.
  assign halt_in_id = (state == ST_RUN) && id_valid && is_halt(if_id_instr) &&
                      !redirect && !stall;
  assign pc_load    = (state == ST_RUN) && redirect;
  assign pc_hold    = (state == ST_HALTED) || stall || halt_in_id;

  fetch_pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .hold    (pc_hold),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  // NOTE: the IF/ID register is a handful of flops, not a memory, so it is reset to a NOP bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      if_id_instr <= INSTR_NOP;
      id_pc       <= '0;
      id_valid    <= 1'b0;
      fetch_cnt   <= '0;
    end else if (state == ST_RUN) begin
      if (redirect) begin
        if_id_instr <= INSTR_NOP;
        id_valid    <= 1'b0;
      end else if (stall) begin
        if_id_instr <= if_id_instr;
      end else if (halt_in_id) begin
        state       <= ST_HALTED;
        if_id_instr <= INSTR_NOP;
        id_valid    <= 1'b0;
      end else begin
        if_id_instr <= imem_rdata;
        id_pc       <= pc;
        id_valid    <= 1'b1;
        if (fetch_cnt != '1) begin
          fetch_cnt <= fetch_cnt + CNT_STEP;
        end
      end
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == ST_HALTED);
  assign id_op     = if_id_instr[OP_MSB:OP_LSB];
  assign id_funct  = if_id_instr[FUNCT_MSB:FUNCT_LSB];
  assign id_rs     = if_id_instr[RS_MSB:RS_LSB];
  assign id_rt     = if_id_instr[RT_MSB:RT_LSB];
  assign id_imm8   = if_id_instr[IMM8_MSB:IMM8_LSB];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: straight-line fetch, stall, redirect, halt,
// halt squash, async reset, PC wrap and counter saturation (second instance, CNT_W=2).
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  id_op, id_funct, id_rs, id_rt;
  logic [7:0]  id_imm8;
  logic [15:0] id_pc;
  logic        id_valid, halted;
  logic [15:0] fetch_cnt;

  logic [15:0] imem_addr2;
  logic [15:0] imem_rdata2;
  logic [3:0]  id_op2, id_funct2, id_rs2, id_rt2;
  logic [7:0]  id_imm82;
  logic [15:0] id_pc2;
  logic        id_valid2, halted2;
  logic [1:0]  fetch_cnt2;

  logic [15:0] imem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = imem[imem_addr];
  assign imem_rdata2 = imem[imem_addr2];

  fetch_decode_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_op(id_op), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
    .id_imm8(id_imm8), .id_pc(id_pc), .id_valid(id_valid), .halted(halted),
    .fetch_cnt(fetch_cnt)
  );

  fetch_decode_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_op(id_op2), .id_funct(id_funct2), .id_rs(id_rs2), .id_rt(id_rt2),
    .id_imm8(id_imm82), .id_pc(id_pc2), .id_valid(id_valid2), .halted(halted2),
    .fetch_cnt(fetch_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] word;
    logic [3:0]  op;
    logic [3:0]  funct;
  } vec_t;

  vec_t straight [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) imem[i] = 16'h1111;
    straight[0] = '{16'h0F21, 4'h0, 4'h1};
    straight[1] = '{16'h0E31, 4'h0, 4'h1};
    straight[2] = '{16'h8402, 4'h8, 4'h2};
    straight[3] = '{16'hB503, 4'hB, 4'h3};
    straight[0].funct = 4'h1;
    straight[1].funct = 4'h1;
    for (int i = 0; i < 4; i++) imem[i] = straight[i].word;

    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    #12;
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", id_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_cnt", fetch_cnt, 16'h0);
    check("rst_op", id_op, 4'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Straight-line fetch
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t2_op%0d", i), id_op, straight[i].op);
      check($sformatf("t2_funct%0d", i), id_funct, straight[i].funct);
      check($sformatf("t2_pc%0d", i), id_pc, i);
      check($sformatf("t2_valid%0d", i), id_valid, 1'b1);
    end
    check("t2_cnt", fetch_cnt, 16'd4);
    check("t2_cnt2_sat", fetch_cnt2, 2'd3);
    check("t2_addr", imem_addr, 16'h0004);

    // Stall with 0x0F21 in ID at id_pc=5
    imem[4] = 16'h2222; imem[5] = 16'h0F21; imem[6] = 16'h3456;
    tick(); tick();
    check("t3_pre_pc", id_pc, 16'h0005);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3_hold_pc", id_pc, 16'h0005);
      check("t3_hold_op", id_op, 4'h0);
      check("t3_hold_rs", id_rs, 4'hF);
      check("t3_hold_rt", id_rt, 4'h2);
      check("t3_hold_imm", id_imm8, 8'h21);
      check("t3_hold_valid", id_valid, 1'b1);
      check("t3_hold_addr", imem_addr, 16'h0006);
    end
    check("t3_hold_cnt", fetch_cnt, 16'd6);
    stall = 1'b0;
    tick();
    check("t3_resume_pc", id_pc, 16'h0006);
    check("t3_resume_op", id_op, 4'h3);
    check("t3_resume_funct", id_funct, 4'h6);
    check("t3_resume_cnt", fetch_cnt, 16'd7);
    check("t3_cnt2_sat", fetch_cnt2, 2'd3);

    // Redirect and stall together: redirect wins
    imem[16'h0040] = 16'hA5C3;
    redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    tick();
    check("t4_addr", imem_addr, 16'h0040);
    check("t4_flush_valid", id_valid, 1'b0);
    check("t4_flush_op", id_op, 4'h0);
    redirect = 1'b0; stall = 1'b0;
    tick();
    check("t4_pc", id_pc, 16'h0040);
    check("t4_valid", id_valid, 1'b1);
    check("t4_op", id_op, 4'hA);
    check("t4_rs", id_rs, 4'h5);
    check("t4_imm", id_imm8, 8'hC3);
    check("t4_cnt", fetch_cnt, 16'd8);

    // PC wrap
    imem[16'hFFFF] = 16'h7777;
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    check("t6_addr_ffff", imem_addr, 16'hFFFF);
    redirect = 1'b0;
    tick();
    check("t6_id_pc", id_pc, 16'hFFFF);
    check("t6_op", id_op, 4'h7);
    check("t6_wrap", imem_addr, 16'h0000);

    // Halt squashed by a redirect in the same cycle
    imem[16'h0100] = 16'h0000; imem[16'h0200] = 16'h4321;
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    tick();
    check("t5s_id_pc", id_pc, 16'h0100);
    check("t5s_valid", id_valid, 1'b1);
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    check("t5s_halted", halted, 1'b0);
    check("t5s_addr", imem_addr, 16'h0200);
    redirect = 1'b0;
    tick();
    check("t5s_tgt_pc", id_pc, 16'h0200);
    check("t5s_tgt_op", id_op, 4'h4);
    check("t5s_tgt_valid", id_valid, 1'b1);
    check("t5s_halted2", halted, 1'b0);

    // Asynchronous reset mid-run at pc=0x0023
    redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    redirect = 1'b0;
    tick(); tick(); tick();
    check("t1_pre_addr", imem_addr, 16'h0023);
    #2 reset = 1'b0;
    #1;
    check("t1_addr", imem_addr, 16'h0000);
    check("t1_valid", id_valid, 1'b0);
    check("t1_halted", halted, 1'b0);
    check("t1_cnt", fetch_cnt, 16'h0);
    check("t1_cnt2", fetch_cnt2, 2'd0);
    check("t1_id_pc", id_pc, 16'h0);

    // Real halt at imem[2]
    imem[0] = 16'h5000; imem[1] = 16'h6001; imem[2] = 16'h0000; imem[3] = 16'h7002;
    @(posedge clk); #1;
    reset = 1'b1;
    tick(); tick(); tick();
    check("t5_id_pc", id_pc, 16'h0002);
    check("t5_in_id_valid", id_valid, 1'b1);
    check("t5_not_yet", halted, 1'b0);
    check("t5_cnt_pre", fetch_cnt, 16'd3);
    tick();
    check("t5_halted", halted, 1'b1);
    check("t5_valid", id_valid, 1'b0);
    check("t5_addr", imem_addr, 16'h0003);
    check("t5_cnt", fetch_cnt, 16'd3);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    check("t5_redir_addr", imem_addr, 16'h0003);
    check("t5_redir_halted", halted, 1'b1);
    redirect = 1'b0;
    tick(); tick();
    check("t5_frozen_addr", imem_addr, 16'h0003);
    check("t5_frozen_valid", id_valid, 1'b0);
    check("t5_frozen_cnt", fetch_cnt, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
